// File: rtl/rram_adc_readout_seq.sv
// RRAM column readout sequencer: steps the SL mux, strobes the lane ADCs, accumulates counts, drains them to a FIFO.
// Define ADC_BUBBLE_CORRECT_EN to majority-filter thermometer codes before counting; default is a plain popcount.
module rram_adc_readout_seq #(
    parameter int NUM_ADC         = 32,
    parameter int ADC_WIDTH_THERM = 15,
    parameter int MUX_RATIO       = 16,
    parameter int ACC_WIDTH       = 16,
    parameter int DATAOUT_WIDTH   = 64,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 acc_mode,
    input  logic [$clog2(MUX_RATIO):0]           num_steps,
    output logic [$clog2(MUX_RATIO)-1:0]         SL_MUX_SEL,
    output logic                                 ADC_CLK,
    output logic                                 ADC_CLKb,
    input  logic [NUM_ADC*ADC_WIDTH_THERM-1:0]   ADCOUT_THERM,
    output logic                                 push_n_oFIFO,
    input  logic                                 full_oFIFO,
    output logic [DATAOUT_WIDTH-1:0]             din_oFIFO,
    output logic                                 busy,
    output logic                                 done
);

    localparam int SEL_W  = $clog2(MUX_RATIO);
    localparam int STEP_W = SEL_W + 1;
    localparam int CNT_W  = $clog2(ADC_WIDTH_THERM + 1);
    localparam int NWORDS = NUM_ADC * ACC_WIDTH / DATAOUT_WIDTH;
    localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, EVAL, CAPTURE, DRAIN} state_t;

    state_t                                  state, state_next;
    logic [NUM_ADC-1:0][ACC_WIDTH-1:0]       acc, acc_sum;
    logic [NWORDS-1:0][DATAOUT_WIDTH-1:0]    acc_words;
    logic [SEL_W-1:0]                        sel;
    logic [STEP_W-1:0]                       steps_lat, steps_clamped;
    logic                                    mode_lat;
    logic [SET_W-1:0]                        settle_cnt;
    logic [WORD_W-1:0]                       word_idx;
    logic                                    last_step, last_word, settle_done, drain_push;

    function automatic logic [CNT_W-1:0] therm_count(input logic [ADC_WIDTH_THERM-1:0] t);
        logic [CNT_W-1:0] c;
`ifdef ADC_BUBBLE_CORRECT_EN
        logic [ADC_WIDTH_THERM+1:0] ext;
        // Out-of-range neighbours: below bit 0 reads as 1, above the MSB reads as 0.
        ext = {1'b0, t, 1'b1};
        c   = '0;
        for (int j = 0; j < ADC_WIDTH_THERM; j++)
            c += CNT_W'((ext[j] & ext[j+1]) | (ext[j] & ext[j+2]) | (ext[j+1] & ext[j+2]));
`else
        c = '0;
        for (int j = 0; j < ADC_WIDTH_THERM; j++)
            c += CNT_W'(t[j]);
`endif
        return c;
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        steps_clamped = num_steps;
        if (num_steps == '0)
            steps_clamped = STEP_W'(1);
        else if (num_steps > STEP_W'(MUX_RATIO))
            steps_clamped = STEP_W'(MUX_RATIO);
    end

    always_comb begin : lane_add
        logic [ACC_WIDTH:0] sum;
        acc_sum = '0;
        for (int i = 0; i < NUM_ADC; i++) begin
            sum = {1'b0, acc[i]}
                + (ACC_WIDTH+1)'(therm_count(ADCOUT_THERM[i*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]));
            acc_sum[i] = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
        end
    end

    assign acc_words   = acc;
    assign last_step   = (STEP_W'(sel) + STEP_W'(1)) == steps_lat;
    assign last_word   = word_idx == WORD_W'(NWORDS - 1);
    assign settle_done = settle_cnt == SET_W'(SETTLE_CYCLES - 1);
    assign drain_push  = (state == DRAIN) && !full_oFIFO && !abort;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = SETTLE;
                SETTLE:  if (settle_done) state_next = EVAL;
                EVAL:    state_next = CAPTURE;
                CAPTURE: state_next = (mode_lat && !last_step) ? SETTLE : DRAIN;
                DRAIN:   if (drain_push && last_word) state_next = last_step ? IDLE : SETTLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ADC_CLK      = (state == EVAL);
        ADC_CLKb     = !ADC_CLK;
        push_n_oFIFO = !drain_push;
        busy         = (state != IDLE);
        din_oFIFO    = acc_words[word_idx];
    end

    assign SL_MUX_SEL = sel;

    // NOTE: the accumulators are plain flops, not a RAM, so they take the async reset like the rest of the state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            sel        <= '0;
            steps_lat  <= STEP_W'(1);
            mode_lat   <= 1'b0;
            settle_cnt <= '0;
            word_idx   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                case (state)
                    IDLE: if (start) begin
                        mode_lat   <= acc_mode;
                        steps_lat  <= steps_clamped;
                        acc        <= '0;
                        sel        <= '0;
                        settle_cnt <= '0;
                        word_idx   <= '0;
                    end
                    SETTLE: settle_cnt <= settle_cnt + SET_W'(1);
                    CAPTURE: begin
                        acc <= acc_sum;
                        if (mode_lat && !last_step) begin
                            sel        <= sel + SEL_W'(1);
                            settle_cnt <= '0;
                        end else begin
                            word_idx <= '0;
                        end
                    end
                    DRAIN: if (drain_push) begin
                        if (!last_word) begin
                            word_idx <= word_idx + WORD_W'(1);
                        end else if (last_step) begin
                            done <= 1'b1;
                        end else begin
                            // Per-step mode: next column starts from empty accumulators.
                            acc        <= '0;
                            sel        <= sel + SEL_W'(1);
                            settle_cnt <= '0;
                            word_idx   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
